// File: rtl/out_vec_monitor_if.sv
// out_vec_monitor_if
//   Bundles the sampled controller vector, the soft clear, the FIFO read port
//   and the status outputs of out_vec_monitor.
//   master : the agent that drives y_in/clr/rd_en and observes status
//   slave  : the monitor itself
//   y_in[22:0]   controller output vector (bit 0 = y1 ... bit 22 = y23)
//   clr          synchronous soft clear, same effect as reset
//   rd_en        pop request for the FIFO head
//   rd_data      popped vector (registered), rd_valid one-cycle pulse
//   empty/full   FIFO occupancy flags, level = occupancy
//   overflow     sticky dropped-capture flag
//   stall        high while the FSM is in STALL
//   evt_cnt      saturating count of accepted change events
//   state        FSM encoding (IDLE=0, RUN=1, STALL=2)
interface out_vec_monitor_if #(
   parameter int DEPTH = 8
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic [22:0]   y_in;
   logic          clr;
   logic          rd_en;
   logic [22:0]   rd_data;
   logic          rd_valid;
   logic          empty;
   logic          full;
   logic [LW-1:0] level;
   logic          overflow;
   logic          stall;
   logic [15:0]   evt_cnt;
   logic [1:0]    state;

   modport master (
      output y_in, clr, rd_en,
      input  rd_data, rd_valid, empty, full, level, overflow, stall, evt_cnt, state
   );

   modport slave (
      input  y_in, clr, rd_en,
      output rd_data, rd_valid, empty, full, level, overflow, stall, evt_cnt, state
   );
endinterface

// File: rtl/out_vec_monitor.sv
// out_vec_monitor
//   Watches a 23-bit controller output vector, captures every change into a
//   small FIFO and flags a stall when the vector stays frozen for STALL_LIMIT
//   consecutive samples.
//   clk  : single clock, all state on its rising edge
//   rst  : synchronous active-high reset
//   bus  : out_vec_monitor_if.slave (y_in, clr, rd_en in; FIFO read data and
//          status out). Every output is driven straight from a flop.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting for the first non-zero vector; no change events counted
//   RUN   | vector is moving; each change is captured and counted
//   STALL | vector unchanged for STALL_LIMIT samples; next change -> RUN
module out_vec_monitor #(
   parameter int DEPTH       = 8,
   parameter int STALL_LIMIT = 16
) (
   input logic            clk,
   input logic            rst,
   out_vec_monitor_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [7:0]    LIMIT = 8'(STALL_LIMIT);
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [22:0]   prev_q;
   logic [7:0]    run_q;
   logic [7:0]    run_d;
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [LW-1:0] level_q;
   logic [LW-1:0] level_d;
   logic          empty_q;
   logic          full_q;
   logic          ovf_q;
   logic          stall_q;
   logic          rd_valid_q;
   logic [22:0]   rd_data_q;
   logic [15:0]   evt_q;

   logic          soft_rst;
   logic          changed;
   logic          push;
   logic          evt_inc;
   logic          pop;
   logic          do_push;
   logic          drop;

   logic [22:0]   mem [DEPTH];

   assign soft_rst = rst | bus.clr;
   assign changed  = (bus.y_in != prev_q);

   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      push    = 1'b0;
      evt_inc = 1'b0;
      case (state_q)
         IDLE: begin
            // The first non-zero vector is captured but is not a change event.
            if (bus.y_in != 23'd0) begin
               state_d = RUN;
               run_d   = 8'd0;
               push    = 1'b1;
            end
         end
         RUN, STALL: begin
            if (changed) begin
               state_d = RUN;
               run_d   = 8'd0;
               push    = 1'b1;
               evt_inc = 1'b1;
            end else begin
               if (run_q < LIMIT) begin
                  run_d = run_q + 8'd1;
               end
               // Enter STALL on the same edge the counter lands on the limit.
               if (state_q == RUN && run_d == LIMIT) begin
                  state_d = STALL;
               end
            end
         end
         default: begin
            state_d = IDLE;
            run_d   = 8'd0;
         end
      endcase
   end

   // Pop is gated by empty, so a push into an empty FIFO never falls through.
   // When full, a pop frees the slot the simultaneous push lands in.
   assign pop     = bus.rd_en & ~empty_q;
   assign do_push = push & (~full_q | pop);
   assign drop    = push & full_q & ~pop;
   assign level_d = level_q + LW'(do_push) - LW'(pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         prev_q     <= 23'd0;
         run_q      <= 8'd0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         ovf_q      <= 1'b0;
         stall_q    <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= 23'd0;
         evt_q      <= 16'd0;
      end else if (bus.clr) begin
         state_q    <= IDLE;
         prev_q     <= 23'd0;
         run_q      <= 8'd0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         ovf_q      <= 1'b0;
         stall_q    <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= 23'd0;
         evt_q      <= 16'd0;
      end else begin
         state_q    <= state_d;
         prev_q     <= bus.y_in;
         run_q      <= run_d;
         level_q    <= level_d;
         empty_q    <= (level_d == '0);
         full_q     <= (level_d == LVL_FULL);
         stall_q    <= (state_d == STALL);
         rd_valid_q <= pop;
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q  <= rd_ptr_q + AW'(1);
            rd_data_q <= mem[rd_ptr_q];
         end
         if (drop) begin
            ovf_q <= 1'b1;
         end
         if (evt_inc && evt_q != 16'hFFFF) begin
            evt_q <= evt_q + 16'd1;
         end
      end
   end

   // Storage is never cleared; pointers and level hide stale entries.
   always_ff @(posedge clk) begin
      if (!soft_rst && do_push) begin
         mem[wr_ptr_q] <= bus.y_in;
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.empty    = empty_q;
   assign bus.full     = full_q;
   assign bus.level    = level_q;
   assign bus.overflow = ovf_q;
   assign bus.stall    = stall_q;
   assign bus.evt_cnt  = evt_q;
   assign bus.state    = state_q;

endmodule

// File: tb/tb_out_vec_monitor.sv
module tb_out_vec_monitor;
   localparam int DEPTH = 8;
   localparam int LIMIT = 16;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   out_vec_monitor_if #(.DEPTH(DEPTH)) bus ();

   out_vec_monitor #(.DEPTH(DEPTH), .STALL_LIMIT(LIMIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model + scoreboard queue of captured vectors
   int          m_state;
   logic [22:0] m_prev;
   int          m_run;
   int          m_evt;
   bit          m_ovf;
   logic [22:0] q[$];

   task automatic cycle(input logic [22:0] y, input bit rd, input bit c, input bit r);
      logic [22:0] popv;
      bit pop, push, was_full;
      popv = '0;
      bus.y_in  = y;
      bus.rd_en = rd;
      bus.clr   = c;
      rst       = r;
      @(posedge clk);
      #1;
      if (r || c) begin
         m_state = 0; m_prev = '0; m_run = 0; m_evt = 0; m_ovf = 0;
         q.delete();
         total++;
         if (bus.rd_valid !== 1'b0 || bus.rd_data !== 23'd0) begin
            bad++;
            $display("FAIL rd_after_clear got valid=%0b data=%h exp valid=0 data=000000", bus.rd_valid, bus.rd_data);
         end
      end else begin
         pop      = rd && (q.size() > 0);
         was_full = (q.size() == DEPTH);
         push     = 0;
         if (m_state == 0) begin
            if (y != 23'd0) begin push = 1; m_state = 1; m_run = 0; end
         end else if (y != m_prev) begin
            push = 1; m_state = 1; m_run = 0;
            if (m_evt < 65535) m_evt++;
         end else begin
            if (m_run < LIMIT) m_run++;
            if (m_state == 1 && m_run == LIMIT) m_state = 2;
         end
         if (pop) popv = q.pop_front();
         if (push) begin
            if (!was_full || pop) q.push_back(y);
            else m_ovf = 1;
         end
         m_prev = y;
         total++;
         if (pop) begin
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== popv) begin
               bad++;
               $display("FAIL rd_pop got valid=%0b data=%h exp valid=1 data=%h", bus.rd_valid, bus.rd_data, popv);
            end
         end else if (bus.rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL rd_spurious got valid=%0b exp valid=0", bus.rd_valid);
         end
      end
   endtask

   task automatic test_reset();
      cycle(23'd0, 0, 0, 1);
      for (int i = 0; i < 10; i++) cycle(23'd0, 0, 0, 0);
      total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
      total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", bus.empty); end
      total++; if (bus.evt_cnt !== 16'd0) begin bad++; $display("FAIL reset_evt got=%0d exp=0", bus.evt_cnt); end
      total++; if (bus.level !== LW'(0)) begin bad++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
      total++; if (bus.full !== 1'b0 || bus.overflow !== 1'b0 || bus.stall !== 1'b0) begin
         bad++; $display("FAIL reset_flags got full=%0b ovf=%0b stall=%0b exp 0 0 0", bus.full, bus.overflow, bus.stall);
      end
   endtask

   task automatic test_order();
      cycle(23'd0, 0, 0, 1);
      cycle(23'h000001, 0, 0, 0);
      cycle(23'h400000, 0, 0, 0);
      cycle(23'h008000, 0, 0, 0);
      total++; if (bus.level !== LW'(3)) begin bad++; $display("FAIL order_level got=%0d exp=3", bus.level); end
      for (int i = 0; i < 3; i++) cycle(23'h008000, 1, 0, 0);
      total++; if (bus.evt_cnt !== 16'd2) begin bad++; $display("FAIL order_evt got=%0d exp=2", bus.evt_cnt); end
      total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL order_empty got=%0b exp=1", bus.empty); end
   endtask

   task automatic test_stall();
      cycle(23'd0, 0, 0, 1);
      cycle(23'h400000, 0, 0, 0);
      total++; if (bus.state !== 2'd1) begin bad++; $display("FAIL stall_run_entry got=%0d exp=1", bus.state); end
      for (int i = 0; i < 15; i++) cycle(23'h400000, 0, 0, 0);
      total++; if (bus.state !== 2'd1 || bus.stall !== 1'b0) begin
         bad++; $display("FAIL stall_early got state=%0d stall=%0b exp 1 0", bus.state, bus.stall);
      end
      cycle(23'h400000, 0, 0, 0);
      total++; if (bus.state !== 2'd2 || bus.stall !== 1'b1) begin
         bad++; $display("FAIL stall_enter got state=%0d stall=%0b exp 2 1", bus.state, bus.stall);
      end
      for (int i = 0; i < 5; i++) cycle(23'h400000, 0, 0, 0);
      total++; if (bus.state !== 2'd2) begin bad++; $display("FAIL stall_hold got=%0d exp=2", bus.state); end
      cycle(23'h000400, 0, 0, 0);
      total++; if (bus.state !== 2'd1 || bus.stall !== 1'b0) begin
         bad++; $display("FAIL stall_exit got state=%0d stall=%0b exp 1 0", bus.state, bus.stall);
      end
      total++; if (bus.level !== LW'(2) || bus.evt_cnt !== 16'd1) begin
         bad++; $display("FAIL stall_exit_push got level=%0d evt=%0d exp 2 1", bus.level, bus.evt_cnt);
      end
      for (int i = 0; i < 2; i++) cycle(23'h000400, 1, 0, 0);
   endtask

   task automatic test_overflow();
      cycle(23'd0, 0, 0, 1);
      cycle(23'h000001, 0, 0, 0);
      for (int i = 0; i < 9; i++) cycle(23'(i + 2), 0, 0, 0);
      total++; if (bus.full !== 1'b1 || bus.level !== LW'(8)) begin
         bad++; $display("FAIL ovf_full got full=%0b level=%0d exp 1 8", bus.full, bus.level);
      end
      total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b exp=1", bus.overflow); end
      total++; if (bus.evt_cnt !== 16'd9) begin bad++; $display("FAIL ovf_evt got=%0d exp=9", bus.evt_cnt); end
      cycle(23'h7FFFFF, 1, 0, 0);
      total++; if (bus.level !== LW'(8) || bus.full !== 1'b1 || bus.overflow !== 1'b1) begin
         bad++; $display("FAIL ovf_pushpop got level=%0d full=%0b ovf=%0b exp 8 1 1", bus.level, bus.full, bus.overflow);
      end
      for (int i = 0; i < 8; i++) cycle(23'h7FFFFF, 1, 0, 0);
      total++; if (bus.empty !== 1'b1 || bus.level !== LW'(0) || bus.overflow !== 1'b1) begin
         bad++; $display("FAIL ovf_drain got empty=%0b level=%0d ovf=%0b exp 1 0 1", bus.empty, bus.level, bus.overflow);
      end
      cycle(23'h7FFFFF, 1, 0, 0);
   endtask

   task automatic test_empty_pushpop();
      cycle(23'd0, 0, 0, 1);
      cycle(23'h000005, 1, 0, 0);
      total++; if (bus.level !== LW'(1)) begin bad++; $display("FAIL empty_pushpop_level got=%0d exp=1", bus.level); end
      cycle(23'h000005, 1, 0, 0);
      total++; if (bus.level !== LW'(0)) begin bad++; $display("FAIL empty_pushpop_drain got=%0d exp=0", bus.level); end
   endtask

   task automatic test_clr();
      cycle(23'd0, 0, 0, 1);
      cycle(23'h000010, 0, 0, 0);
      cycle(23'h000020, 0, 0, 0);
      cycle(23'h000030, 0, 0, 0);
      for (int i = 0; i < 16; i++) cycle(23'h000030, 0, 0, 0);
      total++; if (bus.stall !== 1'b1 || bus.level !== LW'(3)) begin
         bad++; $display("FAIL clr_setup got stall=%0b level=%0d exp 1 3", bus.stall, bus.level);
      end
      cycle(23'h000030, 1, 1, 0);
      total++; if (bus.empty !== 1'b1 || bus.stall !== 1'b0 || bus.overflow !== 1'b0) begin
         bad++; $display("FAIL clr_flags got empty=%0b stall=%0b ovf=%0b exp 1 0 0", bus.empty, bus.stall, bus.overflow);
      end
      total++; if (bus.evt_cnt !== 16'd0 || bus.state !== 2'd0 || bus.level !== LW'(0)) begin
         bad++; $display("FAIL clr_state got evt=%0d state=%0d level=%0d exp 0 0 0", bus.evt_cnt, bus.state, bus.level);
      end
      cycle(23'd0, 1, 0, 0);
      // rst wins over a simultaneous change event and pop
      cycle(23'h000001, 0, 0, 0);
      cycle(23'h000002, 1, 0, 1);
      total++; if (bus.evt_cnt !== 16'd0 || bus.state !== 2'd0 || bus.level !== LW'(0)) begin
         bad++; $display("FAIL rst_priority got evt=%0d state=%0d level=%0d exp 0 0 0", bus.evt_cnt, bus.state, bus.level);
      end
   endtask

   task automatic test_random();
      logic [22:0] y;
      bit chg;
      y = '0;
      cycle(23'd0, 0, 0, 1);
      for (int i = 0; i < 600; i++) begin
         chg = ((i % 100) < 50) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 19) == 0);
         if (chg) y = ($urandom_range(0, 7) == 0) ? 23'd0 : 23'($urandom);
         cycle(y, $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0, 0);
         total++;
         if (bus.state !== 2'(m_state) || bus.level !== LW'(q.size()) || bus.evt_cnt !== 16'(m_evt) ||
             bus.overflow !== m_ovf || bus.stall !== (m_state == 2) ||
             bus.empty !== (q.size() == 0) || bus.full !== (q.size() == DEPTH)) begin
            bad++;
            $display("FAIL random_status cyc=%0d got state=%0d level=%0d evt=%0d ovf=%0b stall=%0b empty=%0b full=%0b exp state=%0d level=%0d evt=%0d ovf=%0b",
                     i, bus.state, bus.level, bus.evt_cnt, bus.overflow, bus.stall, bus.empty, bus.full,
                     m_state, q.size(), m_evt, m_ovf);
         end
      end
   endtask

   initial begin
      total = 0; bad = 0;
      m_state = 0; m_prev = '0; m_run = 0; m_evt = 0; m_ovf = 0;
      bus.y_in = '0; bus.rd_en = 1'b0; bus.clr = 1'b0; rst = 1'b1;
      test_reset();
      test_order();
      test_stall();
      test_overflow();
      test_empty_pushpop();
      test_clr();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/out_vec_monitor.md
OUT_VEC_MONITOR -- requirements
Module: out_vec_monitor

Interface
REQ-001 Parameter DEPTH, default 8: capture FIFO depth in entries, power of two, minimum 2.
REQ-002 Parameter STALL_LIMIT, default 16: number of consecutive unchanged samples that declares a stall, range 2..255.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst  input  1: synchronous active-high reset.
REQ-005 y_in  input  23: controller output vector, bit 0 = y1 ... bit 22 = y23, sampled every clk.
REQ-006 clr  input  1: synchronous soft clear; same effect as rst.
REQ-007 rd_en  input  1: pop request for the FIFO head.
REQ-008 rd_data  output  23: popped vector, registered.
REQ-009 rd_valid  output  1: rd_data valid; one-cycle pulse.
REQ-010 empty  output  1: FIFO holds 0 entries.
REQ-011 full  output  1: FIFO holds DEPTH entries.
REQ-012 level  output  $clog2(DEPTH)+1: current FIFO occupancy.
REQ-013 overflow  output  1: sticky flag, set when a capture is dropped.
REQ-014 stall  output  1: high while the FSM is in STALL.
REQ-015 evt_cnt  output  16: count of accepted change events, saturating.
REQ-016 state  output  2: FSM state encoding, IDLE=0, RUN=1, STALL=2.

Function
REQ-017 The block SHALL register y_in into prev every cycle; a change event is y_in != prev while the FSM is not in IDLE.
REQ-018 In IDLE the block SHALL move to RUN on the first cycle with y_in != 0 and SHALL push that vector into the FIFO.
REQ-019 In RUN or STALL, each change event SHALL push y_in into the FIFO in the same cycle and SHALL increment evt_cnt, which saturates at 0xFFFF.
REQ-020 The run counter SHALL reset to 0 on a change event, increment on each unchanged cycle, and saturate at STALL_LIMIT.
REQ-021 The FSM SHALL move from RUN to STALL on the cycle the run counter reaches STALL_LIMIT.
REQ-022 The FSM SHALL move from STALL to RUN on the next change event; stall SHALL drop in that same cycle's registered update.
REQ-023 A push while full with no simultaneous pop SHALL drop the vector, leave the FIFO unchanged, set overflow, and still count the event in evt_cnt.
REQ-024 When full, a simultaneous push and pop SHALL both succeed; level stays DEPTH and overflow is not set.
REQ-025 rd_en while empty SHALL be ignored: no rd_valid, no pointer movement.
REQ-026 rd_en while not empty SHALL present the head entry on rd_data with rd_valid high one cycle after rd_en (latency 1).
REQ-027 When empty, a simultaneous push and pop SHALL pop nothing and push the vector (no fall-through).
REQ-028 Read and write pointers SHALL wrap modulo DEPTH; level SHALL be pushes minus pops with no wrap error.
REQ-029 FIFO order SHALL be strictly first-in first-out.
REQ-030 Outputs SHALL be glitch-free registered values; no combinational path from y_in to any output.

Reset
REQ-031 On rst or clr, the block SHALL clear in one cycle: prev=0, run counter=0, pointers=0, level=0, empty=1, full=0, overflow=0, stall=0, evt_cnt=0, rd_valid=0, rd_data=0, state=IDLE.
REQ-032 rst or clr SHALL take priority over any simultaneous push, pop or FSM transition, including mid-stall and mid-read.
REQ-033 FIFO storage contents need not be cleared; they SHALL be unreadable until rewritten.

Verification
REQ-034 Reset, then y_in=0 for 10 cycles -> state=0, empty=1, evt_cnt=0, level=0.
REQ-035 y_in=0x000001 then 0x400000 then 0x008000, one cycle each, then rd_en x3 -> rd_data sequence 0x000001, 0x400000, 0x008000 with rd_valid each one cycle after rd_en; evt_cnt=2.
REQ-036 Hold y_in=0x400000 for 16 cycles after RUN entry -> stall=1 and state=2 on the 16th; change to 0x000400 -> state=1, stall=0, level increments by 1.
REQ-037 Apply 9 distinct change events with no reads (DEPTH=8) -> full=1, level=8, overflow=1; then push and rd_en in the same cycle -> level stays 8, overflow remains 1.
REQ-038 With 3 entries queued and stall=1, assert clr for 1 cycle -> next cycle empty=1, stall=0, overflow=0, evt_cnt=0, state=0; a following rd_en produces no rd_valid.
